// File: rtl/sig_gen_pkg.sv
// Shared types for the signal generator and its measurement consumer.
// WAVE_MEAS_AVG_EN adds a sample-sum field to the result record.
package sig_gen_pkg;

   localparam int                WAVE_W    = 5;
   localparam logic [WAVE_W-1:0] WAVE_MAX  = 5'd31;
   localparam int                PER_W_MAX = 16;

   localparam logic [1:0] CH_SQUARE = 2'b00;
   localparam logic [1:0] CH_SAW    = 2'b01;
   localparam logic [1:0] CH_TRI    = 2'b10;

   typedef enum logic {IDLE, MEAS} meas_state_t;

   // period is held at the widest supported counter; narrower builds zero-extend
   typedef struct packed {
      logic [PER_W_MAX-1:0] period;
      logic [WAVE_W-1:0]    min;
      logic [WAVE_W-1:0]    max;
`ifdef WAVE_MEAS_AVG_EN
      logic [PER_W_MAX+4:0] sum;
`endif
   } meas_res_t;

endpackage

// File: rtl/wave_meas_if.sv
// Result port of wave_meas: valid/ready handshake plus the measured fields.
// WAVE_MEAS_AVG_EN adds meas_sum.
interface wave_meas_if #(parameter int PER_W = 16);
   import sig_gen_pkg::*;

   logic              meas_valid;
   logic              meas_ready;
   logic              meas_drop;
   logic [PER_W-1:0]  meas_period;
   logic [WAVE_W-1:0] meas_min;
   logic [WAVE_W-1:0] meas_max;
`ifdef WAVE_MEAS_AVG_EN
   logic [PER_W+4:0]  meas_sum;
`endif

   modport master (
      output meas_valid, meas_drop, meas_period, meas_min, meas_max,
`ifdef WAVE_MEAS_AVG_EN
      output meas_sum,
`endif
      input  meas_ready
   );

   modport slave (
      input  meas_valid, meas_drop, meas_period, meas_min, meas_max,
`ifdef WAVE_MEAS_AVG_EN
      input  meas_sum,
`endif
      output meas_ready
   );

endinterface

// File: rtl/wave_meas_xing_det.sv
// Upward threshold crossing detector: previous sample below THRESH, current at or above.
module wave_xing_det
   import sig_gen_pkg::*;
#(
   parameter int THRESH = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [WAVE_W-1:0] wave_i,
   output logic              xing_o
);

   logic [WAVE_W-1:0] wave_q;

   // one-sample history of the wave
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) wave_q <= '0;
      else        wave_q <= wave_i;
   end

   assign xing_o = (wave_q < WAVE_W'(THRESH)) && (wave_i >= WAVE_W'(THRESH));

endmodule

// File: rtl/wave_meas.sv
// Per-cycle waveform measurement: period, min, max (and sum with WAVE_MEAS_AVG_EN)
// between successive upward crossings, offered on a valid/ready result port.
//
// state | meaning
// IDLE  | waiting for the first crossing of a window
// MEAS  | window open, trackers accumulating
module wave_meas
   import sig_gen_pkg::*;
#(
   parameter int THRESH = 10,
   parameter int PER_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [WAVE_W-1:0] wave,
   input  logic [1:0]        wave_choise,
   wave_meas_if.master       meas
);

   localparam logic [PER_W-1:0] CNT_MAX = '1;
   localparam int               SUM_W   = PER_W + 5;

   meas_state_t       state_q, state_d;
   logic [PER_W-1:0]  cnt_q, cnt_d;
   logic [WAVE_W-1:0] min_q, min_d, max_q, max_d;
   logic [1:0]        choise_q;
   logic              xing, chg, res_new;
   meas_res_t         res_cur, out_q, out_d;
   logic              valid_q, valid_d, drop_q, drop_d;
`ifdef WAVE_MEAS_AVG_EN
   logic [SUM_W-1:0]  sum_q, sum_d;
   logic [SUM_W:0]    sum_ext;
`endif

   wave_xing_det #(.THRESH(THRESH)) u_xing (
      .clk    (clk),
      .rst_n  (rst_n),
      .wave_i (wave),
      .xing_o (xing)
   );

   assign chg = (wave_choise != choise_q);

   // FSM state, trackers and result register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         min_q    <= WAVE_MAX;
         max_q    <= '0;
         choise_q <= '0;
         out_q    <= '0;
         valid_q  <= 1'b0;
         drop_q   <= 1'b0;
`ifdef WAVE_MEAS_AVG_EN
         sum_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         min_q    <= min_d;
         max_q    <= max_d;
         choise_q <= wave_choise;
         out_q    <= out_d;
         valid_q  <= valid_d;
         drop_q   <= drop_d;
`ifdef WAVE_MEAS_AVG_EN
         sum_q    <= sum_d;
`endif
      end
   end

   // window tracking: a crossing closes the current window and opens the next with this sample
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      min_d          = min_q;
      max_d          = max_q;
      res_new        = 1'b0;
      res_cur        = '0;
      res_cur.period = PER_W_MAX'(cnt_q);
      res_cur.min    = min_q;
      res_cur.max    = max_q;
`ifdef WAVE_MEAS_AVG_EN
      sum_d          = sum_q;
      res_cur.sum    = (PER_W_MAX+5)'(sum_q);
      sum_ext        = {1'b0, sum_q} + (SUM_W+1)'(wave);
`endif
      if (chg) begin
         // generator switched waveform: drop the partial window, ignore any crossing now
         state_d = IDLE;
         cnt_d   = '0;
         min_d   = WAVE_MAX;
         max_d   = '0;
`ifdef WAVE_MEAS_AVG_EN
         sum_d   = '0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (xing) begin
                  state_d = MEAS;
                  cnt_d   = PER_W'(1);
                  min_d   = wave;
                  max_d   = wave;
`ifdef WAVE_MEAS_AVG_EN
                  sum_d   = SUM_W'(wave);
`endif
               end
            end
            MEAS: begin
               if (xing) begin
                  res_new = 1'b1;
                  cnt_d   = PER_W'(1);
                  min_d   = wave;
                  max_d   = wave;
`ifdef WAVE_MEAS_AVG_EN
                  sum_d   = SUM_W'(wave);
`endif
               end else if (cnt_q == CNT_MAX) begin
                  // period too long to represent: abandon the window
                  state_d = IDLE;
                  cnt_d   = '0;
                  min_d   = WAVE_MAX;
                  max_d   = '0;
`ifdef WAVE_MEAS_AVG_EN
                  sum_d   = '0;
`endif
               end else begin
                  cnt_d = cnt_q + PER_W'(1);
                  if (wave < min_q) min_d = wave;
                  if (wave > max_q) max_d = wave;
`ifdef WAVE_MEAS_AVG_EN
                  sum_d = sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
`endif
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // output register: load when free or being accepted, otherwise discard and flag
   always_comb begin
      out_d   = out_q;
      valid_d = valid_q;
      drop_d  = 1'b0;
      if (res_new) begin
         if (!valid_q || meas.meas_ready) begin
            out_d   = res_cur;
            valid_d = 1'b1;
         end else begin
            drop_d  = 1'b1;
         end
      end else if (valid_q && meas.meas_ready) begin
         valid_d = 1'b0;
      end
   end

   assign meas.meas_valid  = valid_q;
   assign meas.meas_drop   = drop_q;
   assign meas.meas_period = out_q.period[PER_W-1:0];
   assign meas.meas_min    = out_q.min;
   assign meas.meas_max    = out_q.max;
`ifdef WAVE_MEAS_AVG_EN
   assign meas.meas_sum    = out_q.sum[PER_W+4:0];
`endif

endmodule

// File: tb/tb_wave_meas.sv
// Scoreboard bench for wave_meas: stimulus pushes hand-computed results, monitors pop on handshake.
module tb_wave_meas;
   import sig_gen_pkg::*;

   typedef struct {int period; int mn; int mx; int sum;} exp_t;

   logic       clk    = 1'b0;
   logic       rst_n  = 1'b1;
   logic [4:0] wave   = '0;
   logic [4:0] wave5  = '0;
   logic [1:0] choise = CH_SQUARE;
   logic [1:0] choise5 = CH_SQUARE;

   int n_checks = 0;
   int n_pass   = 0;
   int drop_cnt = 0;
   exp_t q1[$];
   exp_t q5[$];

   logic        hold1 = 1'b0;
   logic [15:0] h_per;
   logic [4:0]  h_min, h_max;

   wave_meas_if #(.PER_W(16)) mif ();
   wave_meas_if #(.PER_W(4))  mif5 ();

   wave_meas #(.THRESH(10), .PER_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .wave(wave), .wave_choise(choise), .meas(mif));

   wave_meas #(.THRESH(10), .PER_W(4)) dut5 (
      .clk(clk), .rst_n(rst_n), .wave(wave5), .wave_choise(choise5), .meas(mif5));

   always #5 clk = ~clk;

   task automatic check(input string name, input longint got, input longint req);
      n_checks++;
      if (got == req) n_pass++;
      else $display("FAIL %s: got %0d required %0d", name, got, req);
   endtask

   task automatic pop1();
      exp_t e;
      n_checks++;
      if (q1.size() == 0) begin
         $display("FAIL res1_unexpected: got period=%0d min=%0d max=%0d, required no result",
                  mif.meas_period, mif.meas_min, mif.meas_max);
      end else begin
         n_pass++;
         e = q1.pop_front();
         check("res1_period", mif.meas_period, e.period);
         check("res1_min", mif.meas_min, e.mn);
         check("res1_max", mif.meas_max, e.mx);
`ifdef WAVE_MEAS_AVG_EN
         check("res1_sum", mif.meas_sum, e.sum);
`endif
      end
   endtask

   task automatic pop5();
      exp_t e;
      n_checks++;
      if (q5.size() == 0) begin
         $display("FAIL res5_unexpected: got period=%0d min=%0d max=%0d, required no result",
                  mif5.meas_period, mif5.meas_min, mif5.meas_max);
      end else begin
         n_pass++;
         e = q5.pop_front();
         check("res5_period", mif5.meas_period, e.period);
         check("res5_min", mif5.meas_min, e.mn);
         check("res5_max", mif5.meas_max, e.mx);
`ifdef WAVE_MEAS_AVG_EN
         check("res5_sum", mif5.meas_sum, e.sum);
`endif
      end
   endtask

   // monitor: compare on accepted results, verify held outputs while stalled, count drops
   always @(negedge clk) begin
      if (!rst_n) begin
         hold1 = 1'b0;
      end else begin
         if (mif.meas_drop) drop_cnt++;
         check("drop5_never", mif5.meas_drop, 0);
         if (hold1) begin
            check("hold_valid", mif.meas_valid, 1);
            check("hold_period", mif.meas_period, h_per);
            check("hold_min", mif.meas_min, h_min);
            check("hold_max", mif.meas_max, h_max);
         end
         if (mif.meas_valid && mif.meas_ready) pop1();
         if (mif5.meas_valid && mif5.meas_ready) pop5();
         hold1 = mif.meas_valid && !mif.meas_ready;
         h_per = mif.meas_period;
         h_min = mif.meas_min;
         h_max = mif.meas_max;
      end
   end

   task automatic step(input logic [4:0] v);
      wave = v;
      @(posedge clk);
      #1;
   endtask

   task automatic step5(input logic [4:0] v);
      wave5 = v;
      @(posedge clk);
      #1;
   endtask

   task automatic square(input int n);
      for (int p = 0; p < n; p++) begin
         for (int i = 0; i < 10; i++) step(5'd20);
         for (int i = 0; i < 10; i++) step(5'd0);
      end
   endtask

   task automatic saw(input int n);
      for (int p = 0; p < n; p++)
         for (int i = 0; i < 20; i++) step(5'(i));
   endtask

   task automatic tri_w(input int n);
      for (int p = 0; p < n; p++) begin
         for (int i = 0; i <= 20; i++) step(5'(i));
         for (int i = 19; i >= 1; i--) step(5'(i));
      end
   endtask

   task automatic push1(input int per, input int mn, input int mx, input int sum, input int n);
      exp_t e;
      e.period = per; e.mn = mn; e.mx = mx; e.sum = sum;
      for (int i = 0; i < n; i++) q1.push_back(e);
   endtask

   task automatic push5(input int per, input int mn, input int mx, input int sum);
      exp_t e;
      e.period = per; e.mn = mn; e.mx = mx; e.sum = sum;
      q5.push_back(e);
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 200 && (q1.size() != 0 || q5.size() != 0); i++) @(posedge clk);
      #1;
      check(name, q1.size() + q5.size(), 0);
      repeat (5) step(wave);
   endtask

   initial begin
      mif.meas_ready  = 1'b1;
      mif5.meas_ready = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      check("rst_valid", mif.meas_valid, 0);
      check("rst_period", mif.meas_period, 0);
      check("rst_min", mif.meas_min, 0);
      check("rst_max", mif.meas_max, 0);
      check("rst_drop", mif.meas_drop, 0);
      check("rst5_valid", mif5.meas_valid, 0);
      check("rst5_period", mif5.meas_period, 0);
      @(posedge clk); #2 rst_n = 1'b1;
      @(posedge clk); #1;

      // 1: square 0/20, one result per 20 cycles from the 2nd rise
      push1(20, 0, 20, 200, 3);
      repeat (3) step(5'd0);
      square(4);
      repeat (5) step(5'd0);
      drain("t1_drain");

      // 2: sawtooth 0..19
      push1(20, 0, 19, 190, 3);
      choise = CH_SAW;
      saw(4);
      step(5'd0);
      drain("t2_drain");

      // 3: triangle with ready held low: first result held, later ones dropped
      mif.meas_ready = 1'b0;
      drop_cnt = 0;
      push1(40, 0, 20, 400, 1);
      choise = CH_TRI;
      tri_w(4);
      repeat (3) step(5'd0);
      @(negedge clk);
      check("t3_drop_count", drop_cnt, 2);
      check("t3_valid_held", mif.meas_valid, 1);
      @(posedge clk); #1;
      mif.meas_ready = 1'b1;
      step(5'd0);
      mif.meas_ready = 1'b0;
      @(negedge clk);
      check("t3_valid_cleared", mif.meas_valid, 0);
      check("t3_queue_empty", q1.size(), 0);
      @(posedge clk); #1;
      mif.meas_ready = 1'b1;

      // 4: waveform change mid-window discards the partial window
      push1(20, 0, 19, 190, 2);
      choise = CH_SQUARE;
      repeat (2) step(5'd0);
      repeat (10) step(5'd20);
      repeat (5) step(5'd0);
      choise = CH_SAW;
      saw(3);
      step(5'd0);
      drain("t4_drain");

      // 4b: crossing in the same cycle as a waveform change is ignored
      push1(20, 0, 20, 200, 1);
      choise = CH_TRI;
      step(5'd20);
      repeat (9) step(5'd20);
      repeat (10) step(5'd0);
      square(2);
      repeat (3) step(5'd0);
      drain("t4b_drain");

      // 5: PER_W=4 instance: period 15 still reported, 15 idle samples abort the window
      push5(15, 0, 20, 20);
      push5(3, 0, 20, 20);
      step5(5'd0);
      step5(5'd20);
      repeat (14) step5(5'd0);
      step5(5'd20);
      repeat (15) step5(5'd0);
      step5(5'd20);
      repeat (2) step5(5'd0);
      step5(5'd20);
      repeat (3) step5(5'd0);
      drain("t5_drain");

      // 6: async reset while a result is pending
      mif.meas_ready = 1'b0;
      repeat (2) step(5'd0);
      square(2);
      repeat (3) step(5'd0);
      @(negedge clk);
      check("t6_pending", mif.meas_valid, 1);
      @(posedge clk); #2 rst_n = 1'b0;
      #1;
      check("t6_rst_valid", mif.meas_valid, 0);
      check("t6_rst_period", mif.meas_period, 0);
      check("t6_rst_min", mif.meas_min, 0);
      check("t6_rst_max", mif.meas_max, 0);
      check("t6_rst_drop", mif.meas_drop, 0);
      @(posedge clk); #2 rst_n = 1'b1;
      @(posedge clk); #1;
      mif.meas_ready = 1'b1;
      push1(20, 0, 20, 200, 2);
      repeat (2) step(5'd0);
      square(3);
      repeat (3) step(5'd0);
      drain("t6_drain");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
